// File: rtl/down_count_monitor_pkg.sv
// Shared types and default widths for the down-counter monitor.
// Both rtl/down_count_monitor.sv and rtl/down_count_monitor_cnt_sync_stable.sv import this package.
package down_count_monitor_pkg;

  localparam int CNT_W_DEF  = 3;
  localparam int WRAP_W_DEF = 8;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } mon_state_t;

endpackage

// File: rtl/down_count_monitor_cnt_sync_stable.sv
// Synchroniser plus hold register for the ripple counter bus.
// Its outputs are registered: o_v is the synchronised value and o_stable says it matched the previous sample.
module cnt_sync_stable
  import down_count_monitor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [CNT_W-1:0] i_cnt,
  output logic [CNT_W-1:0] o_v,
  output logic             o_stable
);

  logic [CNT_W-1:0] r_s1;
  logic [CNT_W-1:0] r_s2;
  logic [CNT_W-1:0] r_h;
  logic [2:0]       r_fill;

  // r_fill blocks the all-zero reset contents from being taken as a real sample
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_h      <= '0;
      r_fill   <= '0;
      o_v      <= '0;
      o_stable <= 1'b0;
    end else begin
      r_s1     <= i_cnt;
      r_s2     <= r_s1;
      r_h      <= r_s2;
      r_fill   <= {r_fill[1:0], 1'b1};
      o_v      <= r_s2;
      o_stable <= r_fill[2] && (r_s2 == r_h);
    end
  end

endmodule

// File: rtl/down_count_monitor.sv
// Monitors a debounced down-counter bus: checks -1 steps, pulses and counts 0->max wraps.
// Build option DOWN_COUNT_MONITOR_WRAP_SAT_EN makes wrap_count saturate instead of rolling over.
//
// state | meaning
// INIT  | no accepted value yet; next stable sample is taken without checks
// TRACK | following a legal down-count; wraps are pulsed and counted
// FAULT | illegal step seen; value still tracked, wraps ignored
module down_count_monitor
  import down_count_monitor_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              clr,
  output logic [CNT_W-1:0]  cnt_stable,
  output logic              cnt_valid,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              step_err
);

  logic [CNT_W-1:0] w_v;
  logic             w_stable;
  logic             w_accept;
  logic             w_legal;
  logic             w_wrap;
  mon_state_t       r_state;

  cnt_sync_stable #(.CNT_W(CNT_W)) u_sync (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_cnt   (cnt_in),
    .o_v     (w_v),
    .o_stable(w_stable)
  );

  assign w_accept = w_stable && ((r_state == INIT) || (w_v != cnt_stable));
  assign w_legal  = (w_v == (cnt_stable - CNT_W'(1)));
  assign w_wrap   = w_legal && (cnt_stable == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= INIT;
      cnt_stable <= '0;
      cnt_valid  <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      step_err   <= 1'b0;
    end else if (clr) begin
      r_state    <= INIT;
      cnt_valid  <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      step_err   <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (w_accept) begin
        cnt_stable <= w_v;
        case (r_state)
          INIT: begin
            cnt_valid <= 1'b1;
            r_state   <= TRACK;
          end
          TRACK: begin
            if (!w_legal) begin
              step_err <= 1'b1;
              r_state  <= FAULT;
            end else if (w_wrap) begin
              wrap_pulse <= 1'b1;
`ifdef DOWN_COUNT_MONITOR_WRAP_SAT_EN
              if (wrap_count != '1) wrap_count <= wrap_count + WRAP_W'(1);
`else
              wrap_count <= wrap_count + WRAP_W'(1);
`endif
            end
          end
          FAULT:   r_state <= FAULT;
          default: r_state <= INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_down_count_monitor.sv
// Randomised self-checking bench for down_count_monitor against an abstract sequence model.
module tb_down_count_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] cnt_in = 3'd0;
  logic [2:0] cnt_stable;
  logic       cnt_valid;
  logic       wrap_pulse;
  logic [7:0] wrap_count;
  logic       step_err;

  int total = 0;
  int bad   = 0;

  // model of what has been accepted so far
  int m_stable = 0;
  int m_have   = 0;
  int m_fault  = 0;
  int m_err    = 0;
  int m_wrap   = 0;
  int m_in     = 0;

  down_count_monitor #(.CNT_W(3), .WRAP_W(8)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .clr(clr),
    .cnt_stable(cnt_stable), .cnt_valid(cnt_valid), .wrap_pulse(wrap_pulse),
    .wrap_count(wrap_count), .step_err(step_err)
  );

  always #5 clk = ~clk;

  task automatic hold_cycles(input int n, output int p);
    p = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (wrap_pulse === 1'b1) p++;
    end
  endtask

  task automatic model_accept(input int v, output int exp_p);
    exp_p = 0;
    if (m_have != 0 && v == m_stable) return;
    if (m_have == 0) begin
      m_have = 1;
    end else if (m_fault == 0) begin
      if (v == (m_stable + 7) % 8) begin
        if (m_stable == 0 && v == 7) begin
          exp_p = 1;
`ifdef DOWN_COUNT_MONITOR_WRAP_SAT_EN
          if (m_wrap < 255) m_wrap++;
`else
          m_wrap = (m_wrap + 1) % 256;
`endif
        end
      end else begin
        m_err   = 1;
        m_fault = 1;
      end
    end
    m_stable = v;
  endtask

  task automatic model_clear();
    m_have = 0; m_fault = 0; m_err = 0; m_wrap = 0;
  endtask

  task automatic step(input int v, input int hold, output int obs_p, output int exp_p);
    cnt_in = 3'(v);
    m_in   = v;
    hold_cycles(hold, obs_p);
    model_accept(v, exp_p);
  endtask

  task automatic test_reset();
    rst = 1'b0; cnt_in = 3'd5; m_in = 5;
    repeat (2) @(negedge clk);
    total++;
    if ({cnt_stable, cnt_valid, wrap_pulse, wrap_count, step_err} !== 14'd0) begin
      bad++; $display("FAIL reset_vals: got %h want 0", {cnt_stable, cnt_valid, wrap_pulse, wrap_count, step_err});
    end
    rst = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      total++;
      if (cnt_valid !== 1'b0) begin
        bad++; $display("FAIL reset_latency edge %0d: valid got %b want 0", e, cnt_valid);
      end
    end
    @(negedge clk);
    total++;
    if (cnt_stable !== 3'd5 || cnt_valid !== 1'b1 || step_err !== 1'b0) begin
      bad++; $display("FAIL reset_first: stable/valid/err got %0d/%b/%b want 5/1/0", cnt_stable, cnt_valid, step_err);
    end
    m_stable = 5; m_have = 1;
  endtask

  task automatic test_legal_sequence();
    int seq[7] = '{4, 3, 2, 1, 0, 7, 6};
    int op, ep, npulse;
    npulse = 0;
    for (int i = 0; i < 7; i++) begin
      step(seq[i], 6, op, ep);
      npulse += op;
      total++;
      if (cnt_stable !== 3'(m_stable) || op != ep) begin
        bad++; $display("FAIL legal_step %0d: stable %0d pulses %0d want %0d pulses %0d", i, cnt_stable, op, m_stable, ep);
      end
    end
    total++;
    if (npulse != 1 || wrap_count !== 8'd1 || step_err !== 1'b0) begin
      bad++; $display("FAIL legal_summary: pulses %0d wrap %0d err %b want 1 1 0", npulse, wrap_count, step_err);
    end
  endtask

  task automatic test_glitch();
    int op, ep;
    step(5, 6, op, ep);
    step(4, 6, op, ep);
    cnt_in = 3'd6;
    @(negedge clk);
    cnt_in = 3'd4;
    hold_cycles(6, op);
    total++;
    if (cnt_stable !== 3'd4 || step_err !== 1'b0 || op != 0) begin
      bad++; $display("FAIL glitch: stable %0d err %b pulses %0d want 4 0 0", cnt_stable, step_err, op);
    end
  endtask

  task automatic test_fault_and_clear();
    int op, ep;
    step(3, 6, op, ep);
    step(1, 6, op, ep);
    total++;
    if (step_err !== 1'b1 || cnt_stable !== 3'd1) begin
      bad++; $display("FAIL skip_err: err %b stable %0d want 1 1", step_err, cnt_stable);
    end
    step(0, 6, op, ep);
    step(7, 6, op, ep);
    total++;
    if (op != 0 || wrap_count !== 8'(m_wrap) || cnt_stable !== 3'd7 || step_err !== 1'b1) begin
      bad++; $display("FAIL fault_wrap: pulses %0d wrap %0d stable %0d err %b want 0 %0d 7 1", op, wrap_count, cnt_stable, step_err, m_wrap);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    total++;
    if (step_err !== 1'b0 || cnt_valid !== 1'b0 || wrap_count !== 8'd0) begin
      bad++; $display("FAIL clr: err %b valid %b wrap %0d want 0 0 0", step_err, cnt_valid, wrap_count);
    end
    hold_cycles(5, op);
    model_accept(m_in, ep);
    total++;
    if (cnt_valid !== 1'b1 || cnt_stable !== 3'(m_stable) || step_err !== 1'b0) begin
      bad++; $display("FAIL clr_reaccept: valid %b stable %0d err %b want 1 %0d 0", cnt_valid, cnt_stable, step_err, m_stable);
    end
  endtask

  task automatic test_wrap_overflow();
    int op, ep, npulse;
    npulse = 0;
    for (int w = 0; w < 256; w++) begin
      for (int k = 6; k >= 0; k--) step(k, 6, op, ep);
      step(7, 6, op, ep);
      npulse += op;
    end
    total++;
    if (npulse != 256 || step_err !== 1'b0) begin
      bad++; $display("FAIL wrap_pulses: got %0d err %b want 256 0", npulse, step_err);
    end
    total++;
    if (wrap_count !== 8'(m_wrap)) begin
      bad++; $display("FAIL wrap_overflow: got %0d want %0d", wrap_count, m_wrap);
    end
  endtask

  task automatic test_clr_collision();
    int op, ep;
    for (int k = 6; k >= 0; k--) step(k, 6, op, ep);
    cnt_in = 3'd7; m_in = 7;
    hold_cycles(4, op);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    total++;
    if (wrap_pulse !== 1'b0 || wrap_count !== 8'd0 || cnt_valid !== 1'b0 || cnt_stable !== 3'd0) begin
      bad++; $display("FAIL clr_collision: pulse %b wrap %0d valid %b stable %0d want 0 0 0 0", wrap_pulse, wrap_count, cnt_valid, cnt_stable);
    end
    hold_cycles(6, op);
    model_accept(7, ep);
    total++;
    if (cnt_stable !== 3'd7 || cnt_valid !== 1'b1 || op != 0 || wrap_count !== 8'd0 || step_err !== 1'b0) begin
      bad++; $display("FAIL clr_collision_after: stable %0d valid %b pulses %0d wrap %0d err %b want 7 1 0 0 0", cnt_stable, cnt_valid, op, wrap_count, step_err);
    end
  endtask

  task automatic test_async_reset();
    int op, ep;
    step(6, 6, op, ep);
    step(5, 3, op, ep);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({cnt_stable, cnt_valid, wrap_pulse, wrap_count, step_err} !== 14'd0) begin
      bad++; $display("FAIL async_reset: got %h want 0", {cnt_stable, cnt_valid, wrap_pulse, wrap_count, step_err});
    end
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    m_stable = 0;
    hold_cycles(8, op);
    model_accept(m_in, ep);
    total++;
    if (cnt_stable !== 3'(m_stable) || cnt_valid !== 1'b1 || step_err !== 1'b0 || wrap_count !== 8'd0) begin
      bad++; $display("FAIL async_reacquire: stable %0d valid %b err %b wrap %0d want %0d 1 0 0", cnt_stable, cnt_valid, step_err, wrap_count, m_stable);
    end
  endtask

  task automatic test_random();
    int op, ep, r, v, g;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      op = 0; ep = 0;
      if (r < 70) begin
        step((m_stable + 7) % 8, $urandom_range(6, 9), op, ep);
      end else if (r < 80) begin
        step($urandom_range(0, 7), $urandom_range(6, 9), op, ep);
      end else if (r < 88) begin
        g = (m_in + $urandom_range(1, 7)) % 8;
        cnt_in = 3'(g);
        @(negedge clk);
        cnt_in = 3'(m_in);
        hold_cycles(6, op);
      end else if (r < 93) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        total++;
        if (cnt_valid !== 1'b0 || wrap_count !== 8'd0 || step_err !== 1'b0) begin
          bad++; $display("FAIL rand_clr %0d: valid %b wrap %0d err %b want 0 0 0", n, cnt_valid, wrap_count, step_err);
        end
        hold_cycles(5, op);
        model_accept(m_in, ep);
      end else begin
        v = m_in;
        step(v, $urandom_range(6, 9), op, ep);
      end
      total++;
      if (cnt_stable !== 3'(m_stable) || cnt_valid !== 1'(m_have) || step_err !== 1'(m_err)
          || wrap_count !== 8'(m_wrap) || op != ep) begin
        bad++;
        $display("FAIL rand_step %0d: stable %0d valid %b err %b wrap %0d pulses %0d want %0d %0d %0d %0d %0d",
                 n, cnt_stable, cnt_valid, step_err, wrap_count, op, m_stable, m_have, m_err, m_wrap, ep);
      end
    end
  endtask

  initial begin
    test_reset();
    test_legal_sequence();
    test_glitch();
    test_fault_and_clear();
    test_wrap_overflow();
    test_clr_collision();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
